// File: rtl/loop_nest_issuer_pkg.sv
// Shared types and helpers for the loop_nest_issuer slice.
// Optional perf counter is enabled by LOOP_NEST_ISSUER_PERF_EN.
package loop_nest_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam int W_DEFAULT = 32;

  // LSB position of level k in a packed DEPTH*w vector
  function automatic int lvl_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/loop_nest_issuer_if.sv
// Start/issue bundle between a pipeline controller and loop_nest_issuer.
// stall_cycles exists only with LOOP_NEST_ISSUER_PERF_EN.
interface loop_nest_issuer_if
  import loop_nest_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = W_DEFAULT
);

  logic                 start;
  logic [DEPTH*W-1:0]   trip_counts;
  logic                 stall;
  logic                 issue;
  logic [DEPTH*W-1:0]   idx;
  logic                 last;
  logic                 busy;
  logic                 empty;
`ifdef LOOP_NEST_ISSUER_PERF_EN
  logic [31:0]          stall_cycles;

  modport master (
    output start, trip_counts, stall,
    input  issue, idx, last, busy, empty,
    input  stall_cycles
  );

  modport slave (
    input  start, trip_counts, stall,
    output issue, idx, last, busy, empty,
    output stall_cycles
  );
`else
  modport master (
    output start, trip_counts, stall,
    input  issue, idx, last, busy, empty
  );

  modport slave (
    input  start, trip_counts, stall,
    output issue, idx, last, busy, empty
  );
`endif

endinterface

// File: rtl/loop_nest_issuer_level.sv
// One odometer digit: counts on en, wraps to 0 after trip-1.
// clear forces the digit back to 0 at the end of a nest.
module loop_level_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] trip,
  output logic [W-1:0] value,
  output logic         at_max
);

  assign at_max = (value == trip - W'(1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      value <= '0;
    end else if (en) begin
      value <= at_max ? '0 : value + W'(1);
    end
  end

endmodule

// File: rtl/loop_nest_issuer.sv
// Issues perfectly nested loop iterations every II cycles after start.
// Build with LOOP_NEST_ISSUER_PERF_EN to add the lost-slot counter.
module loop_nest_issuer
  import loop_nest_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = W_DEFAULT,
  parameter int II    = 1
) (
  input  logic             clk,
  input  logic             rst,
  loop_nest_issuer_if.slave bus
);

  localparam int GW = (II < 1) ? 1 : $clog2(II + 1);
  localparam logic [GW-1:0] II_G = GW'(II);

  state_t             state;
  logic [GW-1:0]      gap;
  logic [DEPTH*W-1:0] trip_q;
  logic [DEPTH*W-1:0] trip_eff;
  logic [DEPTH*W-1:0] idx_w;
  logic [DEPTH-1:0]   en;
  logic [DEPTH-1:0]   at_max;
  logic               idle;
  logic               any_zero;
  logic               accept;
  logic               slot;
  logic               issue_c;
  logic               last_c;

  assign idle = (state == IDLE);

  always_comb begin
    any_zero = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (bus.trip_counts[lvl_lsb(k, W) +: W] == '0) begin
        any_zero = 1'b1;
      end
    end
  end

  assign accept  = !rst && idle && bus.start && !any_zero;
  assign slot    = (state == RUN) && (gap >= II_G);
  assign issue_c = !rst && (accept || slot) && !bus.stall;
  assign last_c  = issue_c && (&at_max);

  // The start cycle compares against the live trips; they are latched after.
  assign trip_eff = idle ? bus.trip_counts : trip_q;
  assign en[0]    = issue_c;

  for (genvar k = 0; k < DEPTH; k++) begin : g_lvl
    loop_level_counter #(
      .W(W)
    ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (last_c),
      .en    (en[k]),
      .trip  (trip_eff[lvl_lsb(k, W) +: W]),
      .value (idx_w[lvl_lsb(k, W) +: W]),
      .at_max(at_max[k])
    );
    if (k < DEPTH - 1) begin : g_carry
      assign en[k+1] = en[k] & at_max[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      gap    <= '0;
      trip_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            trip_q <= bus.trip_counts;
            if (!issue_c) begin
              // stalled start: first issue is pending
              state <= RUN;
              gap   <= II_G;
            end else if (!last_c) begin
              state <= RUN;
              gap   <= GW'(1);
            end
          end
        end
        RUN: begin
          if (issue_c) begin
            if (last_c) begin
              state <= IDLE;
              gap   <= '0;
            end else begin
              gap <= GW'(1);
            end
          end else if (gap < II_G) begin
            gap <= gap + GW'(1);
          end
        end
      endcase
    end
  end

  assign bus.issue = issue_c;
  assign bus.last  = last_c;
  assign bus.idx   = idx_w;
  assign bus.busy  = (state == RUN);
  assign bus.empty = !rst && idle && bus.start && any_zero;

`ifdef LOOP_NEST_ISSUER_PERF_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      stall_cnt <= '0;
    end else if (slot && bus.stall && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign bus.stall_cycles = stall_cnt;
`endif

endmodule

// File: tb/tb_loop_nest_issuer.sv
// Scoreboard bench for loop_nest_issuer: three configurations,
// expected issues queued by stimulus and popped by per-DUT monitors.
module tb_loop_nest_issuer;

  typedef struct {
    int          cyc;
    logic [15:0] idx;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  int   qe[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  loop_nest_issuer_if #(.DEPTH(2), .W(8)) ia ();
  loop_nest_issuer_if #(.DEPTH(2), .W(8)) ib ();
  loop_nest_issuer_if #(.DEPTH(1), .W(8)) ic ();

  loop_nest_issuer #(.DEPTH(2), .W(8), .II(1)) u_a (
    .clk(clk), .rst(rst), .bus(ia.slave));
  loop_nest_issuer #(.DEPTH(2), .W(8), .II(3)) u_b (
    .clk(clk), .rst(rst), .bus(ib.slave));
  loop_nest_issuer #(.DEPTH(1), .W(8), .II(2)) u_c (
    .clk(clk), .rst(rst), .bus(ic.slave));

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, got, exp, cyc);
    end
  endtask

  task automatic flag(string nm, int exp_cyc);
    checks++;
    errors++;
    $display("FAIL %s: at cycle %0d, expected cycle %0d",
             nm, cyc, exp_cyc);
  endtask

  function automatic exp_t mk(int c, logic [15:0] i, logic l);
    exp_t e;
    e.cyc  = c;
    e.idx  = i;
    e.last = l;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_n(int n);
    repeat (n) step();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (qa.size() > 0 && qa[0].cyc < cyc) begin
        e = qa.pop_front();
        flag("a_missed_issue", e.cyc);
      end
      if (ia.issue) begin
        if (qa.size() == 0) flag("a_extra_issue", -1);
        else begin
          e = qa.pop_front();
          chk("a_issue_cycle", 32'(cyc), 32'(e.cyc));
          chk("a_idx", 32'(ia.idx), 32'(e.idx));
          chk("a_last", 32'(ia.last), 32'(e.last));
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (qb.size() > 0 && qb[0].cyc < cyc) begin
        e = qb.pop_front();
        flag("b_missed_issue", e.cyc);
      end
      if (ib.issue) begin
        if (qb.size() == 0) flag("b_extra_issue", -1);
        else begin
          e = qb.pop_front();
          chk("b_issue_cycle", 32'(cyc), 32'(e.cyc));
          chk("b_idx", 32'(ib.idx), 32'(e.idx));
          chk("b_last", 32'(ib.last), 32'(e.last));
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (qc.size() > 0 && qc[0].cyc < cyc) begin
        e = qc.pop_front();
        flag("c_missed_issue", e.cyc);
      end
      if (ic.issue) begin
        if (qc.size() == 0) flag("c_extra_issue", -1);
        else begin
          e = qc.pop_front();
          chk("c_issue_cycle", 32'(cyc), 32'(e.cyc));
          chk("c_idx", 32'(ic.idx), 32'(e.idx));
          chk("c_last", 32'(ic.last), 32'(e.last));
        end
      end
    end
  end

  always @(negedge clk) begin
    int c;
    if (!rst) begin
      if (qe.size() > 0 && qe[0] < cyc) begin
        c = qe.pop_front();
        flag("a_missed_empty", c);
      end
      if (ia.empty) begin
        if (qe.size() == 0) flag("a_extra_empty", -1);
        else begin
          c = qe.pop_front();
          chk("a_empty_cycle", 32'(cyc), 32'(c));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst = 1'b1;
    ia.start = 1'b0; ia.trip_counts = '0; ia.stall = 1'b0;
    ib.start = 1'b0; ib.trip_counts = '0; ib.stall = 1'b0;
    ic.start = 1'b0; ic.trip_counts = '0; ic.stall = 1'b0;
    step();
    step();

    // reset wins over a start in the same cycle
    ia.trip_counts = 16'h0101;
    ia.start = 1'b1;
    @(negedge clk);
    chk("rst_ovr_issue", 32'(ia.issue), 32'd0);
    chk("rst_ovr_last", 32'(ia.last), 32'd0);
    chk("rst_ovr_empty", 32'(ia.empty), 32'd0);
    step();
    ia.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy_a", 32'(ia.busy), 32'd0);
    chk("reset_idx_a", 32'(ia.idx), 32'd0);
    chk("reset_busy_b", 32'(ib.busy), 32'd0);
    chk("reset_busy_c", 32'(ic.busy), 32'd0);
    chk("reset_idx_c", 32'(ic.idx), 32'd0);

    // trips {3,2}, II=1
    step();
    t = cyc;
    ia.trip_counts = {8'd2, 8'd3};
    ia.start = 1'b1;
    qa.push_back(mk(t,     16'h0000, 1'b0));
    qa.push_back(mk(t + 1, 16'h0001, 1'b0));
    qa.push_back(mk(t + 2, 16'h0002, 1'b0));
    qa.push_back(mk(t + 3, 16'h0100, 1'b0));
    qa.push_back(mk(t + 4, 16'h0101, 1'b0));
    qa.push_back(mk(t + 5, 16'h0102, 1'b1));
    @(negedge clk);
    chk("t1_busy_c0", 32'(ia.busy), 32'd0);
    step();
    ia.start = 1'b0;
    @(negedge clk);
    chk("t1_busy_c1", 32'(ia.busy), 32'd1);
    idle_n(4);
    @(negedge clk);
    chk("t1_busy_c5", 32'(ia.busy), 32'd1);
    step();
    @(negedge clk);
    chk("t1_busy_c6", 32'(ia.busy), 32'd0);
    idle_n(2);

    // trips {2,2}, II=3
    step();
    t = cyc;
    ib.trip_counts = {8'd2, 8'd2};
    ib.start = 1'b1;
    qb.push_back(mk(t,     16'h0000, 1'b0));
    qb.push_back(mk(t + 3, 16'h0001, 1'b0));
    qb.push_back(mk(t + 6, 16'h0100, 1'b0));
    qb.push_back(mk(t + 9, 16'h0101, 1'b1));
    step();
    ib.start = 1'b0;
    idle_n(12);

    // trips {4}, II=2, stall over cycles 2..4
    step();
    t = cyc;
    ic.trip_counts = 8'd4;
    ic.start = 1'b1;
    qc.push_back(mk(t,     16'h0000, 1'b0));
    qc.push_back(mk(t + 5, 16'h0001, 1'b0));
    qc.push_back(mk(t + 7, 16'h0002, 1'b0));
    qc.push_back(mk(t + 9, 16'h0003, 1'b1));
    step();
    ic.start = 1'b0;
    step();
    ic.stall = 1'b1;
    idle_n(2);
    step();
    ic.stall = 1'b0;
    idle_n(6);

    // start under stall: first issue is pending until stall drops
    step();
    t = cyc;
    ic.trip_counts = 8'd2;
    ic.start = 1'b1;
    ic.stall = 1'b1;
    qc.push_back(mk(t + 2, 16'h0000, 1'b0));
    qc.push_back(mk(t + 4, 16'h0001, 1'b1));
    step();
    ic.start = 1'b0;
    @(negedge clk);
    chk("c_stall_start_busy", 32'(ic.busy), 32'd1);
    step();
    ic.stall = 1'b0;
    idle_n(4);

    // zero trip then a {1,1} nest
    step();
    t = cyc;
    ia.trip_counts = {8'd0, 8'd5};
    ia.start = 1'b1;
    qe.push_back(t);
    step();
    ia.start = 1'b0;
    @(negedge clk);
    chk("t4_busy_after_empty", 32'(ia.busy), 32'd0);
    chk("t4_empty_one_cycle", 32'(ia.empty), 32'd0);
    step();
    t = cyc;
    ia.trip_counts = {8'd1, 8'd1};
    ia.start = 1'b1;
    qa.push_back(mk(t, 16'h0000, 1'b1));
    step();
    ia.start = 1'b0;
    @(negedge clk);
    chk("t4_busy_single", 32'(ia.busy), 32'd0);
    idle_n(2);

    // trips {4,4}; restart at +3 and at the final issue are ignored
    step();
    t = cyc;
    ia.trip_counts = {8'd4, 8'd4};
    ia.start = 1'b1;
    for (int i = 0; i < 16; i++) begin
      qa.push_back(mk(t + i, {8'(i / 4), 8'(i % 4)}, i == 15));
    end
    step();
    ia.start = 1'b0;
    idle_n(2);
    ia.trip_counts = {8'd2, 8'd2};
    ia.start = 1'b1;
    step();
    ia.start = 1'b0;
    ia.trip_counts = {8'd4, 8'd4};
    idle_n(11);
    ia.start = 1'b1;
    step();
    ia.start = 1'b0;
    @(negedge clk);
    chk("t5_busy_after_last", 32'(ia.busy), 32'd0);
    idle_n(3);

    // reset in the middle of a run
    step();
    t = cyc;
    ia.trip_counts = {8'd4, 8'd4};
    ia.start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      qa.push_back(mk(t + i, {8'(i / 4), 8'(i % 4)}, 1'b0));
    end
    step();
    ia.start = 1'b0;
    idle_n(7);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_issue", 32'(ia.issue), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_idx", 32'(ia.idx), 32'd0);
    chk("t5_rst_busy", 32'(ia.busy), 32'd0);
    idle_n(5);

    // trip 2^W-1 on level 0
    step();
    t = cyc;
    ia.trip_counts = {8'd1, 8'd255};
    ia.start = 1'b1;
    for (int i = 0; i < 255; i++) begin
      qa.push_back(mk(t + i, {8'd0, 8'(i)}, i == 254));
    end
    step();
    ia.start = 1'b0;
    idle_n(258);

`ifdef LOOP_NEST_ISSUER_PERF_EN
    step();
    t = cyc;
    ia.trip_counts = {8'd1, 8'd3};
    ia.start = 1'b1;
    qa.push_back(mk(t,     16'h0000, 1'b0));
    qa.push_back(mk(t + 3, 16'h0001, 1'b0));
    qa.push_back(mk(t + 4, 16'h0002, 1'b1));
    step();
    ia.start = 1'b0;
    ia.stall = 1'b1;
    step();
    step();
    ia.stall = 1'b0;
    idle_n(2);
    @(negedge clk);
    chk("perf_stall_cycles", ia.stall_cycles, 32'd2);
    step();
    t = cyc;
    ia.trip_counts = {8'd1, 8'd1};
    ia.start = 1'b1;
    qa.push_back(mk(t, 16'h0000, 1'b1));
    step();
    ia.start = 1'b0;
    @(negedge clk);
    chk("perf_cleared", ia.stall_cycles, 32'd0);
    idle_n(2);
`endif

    idle_n(3);
    chk("qa_drained", 32'(qa.size()), 32'd0);
    chk("qb_drained", 32'(qb.size()), 32'd0);
    chk("qc_drained", 32'(qc.size()), 32'd0);
    chk("qe_drained", 32'(qe.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
